lsu_dcache_fill_ctl: RTL

LSU_DCACHE_FILL_CTL -- requirements
Module: lsu_dcache_fill_ctl

---
 rtl/lsu_dcache_pkg.sv | 25 ++
 rtl/lsu_dcache_rpl_lfsr.sv | 44 ++++
 rtl/lsu_dcache_fill_ctl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/lsu_dcache_pkg.sv
// Shared definitions for the LSU dcache fill path.
// Holds the fill FSM state encoding, requester/way counts, the replacement
// LFSR width and seed, and a small one-hot helper used by the grant logic.
package lsu_dcache_pkg;

   localparam int unsigned NTHR   = 4;
   localparam int unsigned NWAY   = 4;
   localparam int unsigned PTR_W  = 2;
   localparam int unsigned WAY_W  = 2;
   localparam int unsigned LFSR_W = 5;

   localparam logic [LFSR_W-1:0] LFSR_SEED = 5'b11111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEL  = 2'd1,
      ST_BUSY = 2'd2
   } fill_state_e;

   // One-hot requester vector for a thread index.
   function automatic logic [NTHR-1:0] thr_onehot(input logic [PTR_W-1:0] idx);
      thr_onehot = NTHR'(1) << idx;
   endfunction

endpackage

// File: rtl/lsu_dcache_rpl_lfsr.sv
// Pseudo-random source for dcache victim selection.
// 5-bit Fibonacci LFSR, taps q[1]^q[4] into q[0], stepping only when
// advance is high.
// Ports:
//   clk     - clock
//   arst_l  - asynchronous active-low reset (loads LFSR_SEED)
//   se      - scan enable, no functional effect
//   advance - step the LFSR this cycle
//   q       - current LFSR state
module lsu_dcache_rpl_lfsr
   import lsu_dcache_pkg::*;
(
   input  logic              clk,
   input  logic              arst_l,
   input  logic              se,
   input  logic              advance,
   output logic [LFSR_W-1:0] q
);

   logic              se_unused;
   logic [LFSR_W-1:0] q_nxt;

   assign se_unused = se;

   // Shift up by one bit, feedback enters at bit 0.
   always_comb begin
      q_nxt = q;
      if (advance) begin
         for (int i = 1; i < int'(LFSR_W); i++) begin
            q_nxt[i] = q[i-1];
         end
         q_nxt[0] = q[1] ^ q[4];
      end
   end

   always_ff @(posedge clk or negedge arst_l) begin
      if (!arst_l) begin
         q <= LFSR_SEED;
      end else begin
         q <= q_nxt;
      end
   end

endmodule

// File: rtl/lsu_dcache_fill_ctl.sv
// Dcache fill controller: arbitrates per-thread fill requests round-robin,
// picks a victim way and tracks the fill until fill_done.
// FSM: IDLE -> SEL (grant pulse, victim choice, LFSR step) -> BUSY -> IDLE.
// Optional build macro LSU_DCACHE_WAY_LOCK_EN: locked ways are skipped when
// the victim comes from the LFSR; without it set_lock is ignored.
// Ports:
//   clk, arst_l, se - clock, async active-low reset, scan enable
//   fill_req        - per-thread fill request, held until granted
//   set_vld         - valid bits of the indexed set (used in SEL)
//   set_lock        - lock bits of the indexed set (used in SEL)
//   fill_done       - current fill has been written (used in BUSY)
//   fill_gnt        - one-hot grant, high for the SEL cycle only
//   fill_way        - victim way, stable while fill_active
//   fill_active     - a fill is in progress (BUSY)
module lsu_dcache_fill_ctl #(
   parameter int unsigned NTHR = lsu_dcache_pkg::NTHR,
   parameter int unsigned NWAY = lsu_dcache_pkg::NWAY
) (
   input  logic            clk,
   input  logic            arst_l,
   input  logic            se,
   input  logic [NTHR-1:0] fill_req,
   input  logic [NWAY-1:0] set_vld,
   input  logic [NWAY-1:0] set_lock,
   input  logic            fill_done,
   output logic [NTHR-1:0] fill_gnt,
   output logic [1:0]      fill_way,
   output logic            fill_active
);

   import lsu_dcache_pkg::*;

   fill_state_e       state, state_nxt;
   logic [PTR_W-1:0]  rr_ptr, rr_ptr_nxt;
   logic [PTR_W-1:0]  winner, winner_nxt;
   logic [NTHR-1:0]   gnt_nxt;
   logic [WAY_W-1:0]  way_nxt;
   logic              active_nxt;

   logic [LFSR_W-1:0] lfsr_q;
   logic              lfsr_adv_c;

   logic [PTR_W-1:0]  rr_win_c;
   logic [PTR_W-1:0]  rr_idx_c;
   logic              rr_found_c;

   logic [WAY_W-1:0]  rnd_c;
   logic [WAY_W-1:0]  rnd_way_c;
   logic [WAY_W-1:0]  victim_c;

   // Replacement LFSR steps once per SEL cycle; victim sees pre-step value.
   assign lfsr_adv_c = (state == ST_SEL);

   lsu_dcache_rpl_lfsr u_rpl_lfsr (
      .clk     (clk),
      .arst_l  (arst_l),
      .se      (se),
      .advance (lfsr_adv_c),
      .q       (lfsr_q)
   );

   // Round-robin winner: first requester at or above rr_ptr, wrapping.
   always_comb begin
      rr_win_c   = rr_ptr;
      rr_idx_c   = rr_ptr;
      rr_found_c = 1'b0;
      for (int k = 0; k < int'(NTHR); k++) begin
         rr_idx_c = rr_ptr + PTR_W'(k);
         if (!rr_found_c && fill_req[rr_idx_c]) begin
            rr_win_c   = rr_idx_c;
            rr_found_c = 1'b1;
         end
      end
   end

`ifdef LSU_DCACHE_WAY_LOCK_EN
   logic [WAY_W-1:0] lk_idx_c;
   logic             lk_found_c;

   // Random way steered upward past locked ways; all locked keeps rnd.
   always_comb begin
      rnd_c      = {lfsr_q[0], lfsr_q[2]};
      rnd_way_c  = rnd_c;
      lk_idx_c   = rnd_c;
      lk_found_c = 1'b0;
      for (int k = 0; k < int'(NWAY); k++) begin
         lk_idx_c = rnd_c + WAY_W'(k);
         if (!lk_found_c && !set_lock[lk_idx_c]) begin
            rnd_way_c  = lk_idx_c;
            lk_found_c = 1'b1;
         end
      end
   end
`else
   logic lock_unused;

   assign lock_unused = |set_lock;

   always_comb begin
      rnd_c     = {lfsr_q[0], lfsr_q[2]};
      rnd_way_c = rnd_c;
   end
`endif

   // Invalid ways win over the random pick; downward scan leaves the lowest.
   always_comb begin
      victim_c = rnd_way_c;
      for (int k = int'(NWAY) - 1; k >= 0; k--) begin
         if (!set_vld[k]) begin
            victim_c = WAY_W'(k);
         end
      end
   end

   // Next state and next values of all registered outputs.
   always_comb begin
      state_nxt  = state;
      rr_ptr_nxt = rr_ptr;
      winner_nxt = winner;
      gnt_nxt    = '0;
      way_nxt    = fill_way;
      active_nxt = 1'b0;
      case (state)
         ST_IDLE: begin
            if (|fill_req) begin
               state_nxt  = ST_SEL;
               winner_nxt = rr_win_c;
               gnt_nxt    = thr_onehot(rr_win_c);
            end
         end
         ST_SEL: begin
            state_nxt  = ST_BUSY;
            rr_ptr_nxt = winner + PTR_W'(1);
            way_nxt    = victim_c;
            active_nxt = 1'b1;
         end
         ST_BUSY: begin
            if (fill_done) begin
               state_nxt = ST_IDLE;
            end else begin
               active_nxt = 1'b1;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge arst_l) begin
      if (!arst_l) begin
         state       <= ST_IDLE;
         rr_ptr      <= '0;
         winner      <= '0;
         fill_gnt    <= '0;
         fill_way    <= '0;
         fill_active <= 1'b0;
      end else begin
         state       <= state_nxt;
         rr_ptr      <= rr_ptr_nxt;
         winner      <= winner_nxt;
         fill_gnt    <= gnt_nxt;
         fill_way    <= way_nxt;
         fill_active <= active_nxt;
      end
   end

endmodule
